execute_state: RTL and testbench
================================

Name: execute_state

Overview:
- Consumer end of the decode pipeline register in the pipelined OTTER RV32I core.
- Accepts the registered decode-stage bundle: operands, immediates, IR, PC+4 and control bits.
- Performs the ALU operation, resolves branches and jumps, and squashes wrong-path instructions.
- Registers the results into the execute register consumed by the memory stage.

Parameters:
- XLEN, 32, datapath width
- SQUASH_DEPTH, 2, number of accepted younger instructions squashed after a taken control transfer

Ports:
- REG_CLOCK  in  1  clock; all state updates on posedge
- REG_RESET  in  1  synchronous, active-low reset
- DEC_VALID  in  1  decode bundle is a real instruction
- DEC_PC_OUT  in  32  PC+4 of the instruction
- DEC_ALU_A  in  32  ALU operand A (rs1 or U-imm)
- DEC_ALU_B  in  32  ALU operand B (rs2, I-imm, S-imm or PC)
- DEC_RS2  in  32  raw rs2 value (store data, branch compare)
- DEC_J_TYPE, DEC_B_TYPE, DEC_I_TYPE  in  32 each  sign-extended immediates
- DEC_MEM_IR  in  32  instruction word
- DEC_ALU_FUN  in  4  ALU function
- DEC_REGWRITE, DEC_MEMWRITE, DEC_MEMREAD_2  in  1 each  control bits
- DEC_RF_WR_SEL  in  2  writeback select
- MEM_STALL  in  1  memory stage cannot accept; hold all state
- EX_VALID  out  1  execute register holds a live instruction
- EX_ALU_RESULT  out  32  ALU result
- EX_RS2  out  32  store data
- EX_PC_4  out  32  PC+4 passthrough
- EX_MEM_IR  out  32  IR passthrough
- EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD_2  out  1 each  gated control bits
- EX_RF_WR_SEL  out  2  passthrough
- EX_REDIRECT  out  1  one-cycle pulse: fetch must load EX_TARGET
- EX_TARGET  out  32  redirect PC

Behaviour:
- Reset (REG_RESET=0 at posedge): all outputs 0; squash counter 0. Reset wins over stall and redirect.
- Latency: inputs sampled at posedge; all EX_* outputs update at that same edge. This is 1 cycle from the decode register.
- Accept = REG_RESET && !MEM_STALL.
  - When MEM_STALL=1: every output and the squash counter hold.
  - A held EX_REDIRECT=1 is still a single logical redirect. Fetch consumes it only when MEM_STALL=0.
- live = DEC_VALID && (squash_cnt==0).
- ALU_FUN encoding:
  - 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor
  - 0101 srl, 1101 sra, 0110 or, 0111 and, 1001 lui (pass A)
  - Others yield 0.
  - Shifts use B[4:0]. Add/sub wrap modulo 2^32.
- Opcode IR[6:0]:
  - BRANCH 1100011: compare DEC_ALU_A vs DEC_RS2 per funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu. 010/011 never taken. Target = (DEC_PC_OUT-4)+DEC_B_TYPE.
  - JAL 1101111: always taken. Target = (DEC_PC_OUT-4)+DEC_J_TYPE.
  - JALR 1100111: always taken. Target = (DEC_ALU_A+DEC_I_TYPE) with bit0 cleared.
  - Misaligned targets are passed through without exception.
- On accept:
  - EX_VALID <= live.
  - Control bits <= DEC_* AND live.
  - Data fields are always captured.
  - EX_REDIRECT <= live && taken; EX_TARGET <= target when taken, else holds.
- Squash counter:
  - An accepted live taken instruction loads SQUASH_DEPTH.
  - Each subsequent accepted DEC_VALID input while the counter is nonzero decrements it, and that input is squashed.
  - Accepted DEC_VALID=0 bubbles do not decrement.
  - A taken instruction arriving while squashing is itself squashed: no redirect, no reload.
- Reset mid-squash clears the counter; the next valid instruction is live.

Optional Feature:
- Macro: OTTER_EXEC_PERF_EN.
- Defined:
  - Adds outputs EX_BR_TAKEN_CNT[31:0] and EX_SQUASH_CNT[31:0].
  - EX_BR_TAKEN_CNT increments on each accepted live taken instruction. EX_SQUASH_CNT increments on each accepted squashed DEC_VALID input.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package otter_pkg holds:
  - typedef enum alu_fun_t (4-bit codes above)
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
  - funct3 branch constants
  - typedef struct ex_ctrl_t {regwrite, memwrite, memread2, rf_wr_sel}
- Sub-module otter_alu (purely combinational, A, B, alu_fun -> result).
- Branch resolution, squash counter and execute register live in execute_state.

Test Plan:
- Reset: hold REG_RESET=0 for 2 cycles with DEC_VALID=1 -> all EX_* = 0, EX_REDIRECT=0.
- ALU: A=0xFFFFFFF0, B=0x10, add -> 0x00000000. sra with A=0x80000000, B=4 -> 0xF8000000. sltu A=1, B=0xFFFFFFFF -> 1.
- Branch: BEQ, PC_4=0x104, A=RS2=5, B_TYPE=0x20 -> EX_REDIRECT=1, EX_TARGET=0x120. Next two valid inputs (one with MEMWRITE=1) -> EX_VALID=0, EX_MEMWRITE=0. Third input is live.
- JALR: A=0x1001, I=0x6 -> EX_TARGET=0x1006, bit0 cleared. Taken JAL as first squashed slot -> no redirect.
- Stall: MEM_STALL=1 for 3 cycles during squash, with bubbles interleaved -> outputs frozen, counter unchanged. Squash completes after two accepted valid inputs.
- Reset mid-squash after 1 squashed input -> next valid input has EX_VALID=1.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER RV32I execute stage.
//   alu_fun_t      : 4-bit ALU function codes
//   OP_*           : opcodes that transfer control (IR[6:0])
//   F3_*           : branch funct3 codes (IR[14:12])
//   ex_ctrl_t      : control bits carried into the execute register
package otter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memread2;
    logic [1:0] rf_wr_sel;
  } ex_ctrl_t;

endpackage

// File: rtl/otter_alu.sv
// Combinational RV32I ALU.
//   a, b     : operands (shift amount is b[4:0])
//   alu_fun  : function code (see otter_pkg::alu_fun_t); unlisted codes give 0
//   result   : a <op> b, add/sub wrap modulo 2^XLEN
module otter_alu
  import otter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_fun,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    // NOTE: default assignment first so no path leaves result unassigned (no latch).
    result = '0;
    case (alu_fun)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_LUI:  result = a;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_state.sv
// OTTER execute stage: ALU, branch/jump resolution, wrong-path squashing and
// the execute pipeline register feeding the memory stage.
//   REG_CLOCK / REG_RESET : clock, synchronous active-low reset
//   DEC_*                 : registered decode bundle (operands, immediates, IR, PC+4, control)
//   MEM_STALL             : memory stage busy, hold every register
//   EX_*                  : execute register outputs, EX_REDIRECT/EX_TARGET steer fetch
// Optional build macro OTTER_EXEC_PERF_EN adds EX_BR_TAKEN_CNT and EX_SQUASH_CNT.
module execute_state
  import otter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            REG_CLOCK,
  input  logic            REG_RESET,
  input  logic            DEC_VALID,
  input  logic [XLEN-1:0] DEC_PC_OUT,
  input  logic [XLEN-1:0] DEC_ALU_A,
  input  logic [XLEN-1:0] DEC_ALU_B,
  input  logic [XLEN-1:0] DEC_RS2,
  input  logic [XLEN-1:0] DEC_J_TYPE,
  input  logic [XLEN-1:0] DEC_B_TYPE,
  input  logic [XLEN-1:0] DEC_I_TYPE,
  input  logic [31:0]     DEC_MEM_IR,
  input  logic [3:0]      DEC_ALU_FUN,
  input  logic            DEC_REGWRITE,
  input  logic            DEC_MEMWRITE,
  input  logic            DEC_MEMREAD_2,
  input  logic [1:0]      DEC_RF_WR_SEL,
  input  logic            MEM_STALL,
  output logic            EX_VALID,
  output logic [XLEN-1:0] EX_ALU_RESULT,
  output logic [XLEN-1:0] EX_RS2,
  output logic [XLEN-1:0] EX_PC_4,
  output logic [31:0]     EX_MEM_IR,
  output logic            EX_REGWRITE,
  output logic            EX_MEMWRITE,
  output logic            EX_MEMREAD_2,
  output logic [1:0]      EX_RF_WR_SEL,
  output logic            EX_REDIRECT,
  output logic [XLEN-1:0] EX_TARGET
`ifdef OTTER_EXEC_PERF_EN
  ,
  output logic [31:0]     EX_BR_TAKEN_CNT,
  output logic [31:0]     EX_SQUASH_CNT
`endif
);

  localparam int CNT_W = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  logic [CNT_W-1:0] squash_cnt;
  logic [XLEN-1:0]  alu_result;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             live;
  logic             accept;
  ex_ctrl_t         dec_ctrl;
  ex_ctrl_t         ex_ctrl;

  otter_alu #(.XLEN(XLEN)) u_alu (
    .a       (DEC_ALU_A),
    .b       (DEC_ALU_B),
    .alu_fun (DEC_ALU_FUN),
    .result  (alu_result)
  );

  assign accept = REG_RESET && !MEM_STALL;
  assign live   = DEC_VALID && (squash_cnt == '0);

  assign dec_ctrl = '{regwrite:  DEC_REGWRITE,
                      memwrite:  DEC_MEMWRITE,
                      memread2:  DEC_MEMREAD_2,
                      rf_wr_sel: DEC_RF_WR_SEL};

  // Branch compare uses the raw rs2 value, since operand B may hold an immediate.
  // PC-relative targets subtract 4 because the bundle carries PC+4.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (DEC_MEM_IR[6:0])
      OP_BRANCH: begin
        target = (DEC_PC_OUT - XLEN'(4)) + DEC_B_TYPE;
        case (DEC_MEM_IR[14:12])
          F3_BEQ:  taken = (DEC_ALU_A == DEC_RS2);
          F3_BNE:  taken = (DEC_ALU_A != DEC_RS2);
          F3_BLT:  taken = ($signed(DEC_ALU_A) <  $signed(DEC_RS2));
          F3_BGE:  taken = ($signed(DEC_ALU_A) >= $signed(DEC_RS2));
          F3_BLTU: taken = (DEC_ALU_A <  DEC_RS2);
          F3_BGEU: taken = (DEC_ALU_A >= DEC_RS2);
          default: taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        taken  = 1'b1;
        target = (DEC_PC_OUT - XLEN'(4)) + DEC_J_TYPE;
      end
      OP_JALR: begin
        taken  = 1'b1;
        target = (DEC_ALU_A + DEC_I_TYPE) & ~XLEN'(1);
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  always_ff @(posedge REG_CLOCK) begin
    // NOTE: reset is sampled on the clock edge and covers every register here;
    // the design holds no memory arrays, so nothing is left unreset.
    if (!REG_RESET) begin
      EX_VALID      <= 1'b0;
      EX_ALU_RESULT <= '0;
      EX_RS2        <= '0;
      EX_PC_4       <= '0;
      EX_MEM_IR     <= '0;
      ex_ctrl       <= '0;
      EX_REDIRECT   <= 1'b0;
      EX_TARGET     <= '0;
      squash_cnt    <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      EX_VALID      <= live;
      EX_ALU_RESULT <= alu_result;
      EX_RS2        <= DEC_RS2;
      EX_PC_4       <= DEC_PC_OUT;
      EX_MEM_IR     <= DEC_MEM_IR;
      ex_ctrl       <= live ? dec_ctrl : '{regwrite: 1'b0, memwrite: 1'b0,
                                           memread2: 1'b0, rf_wr_sel: dec_ctrl.rf_wr_sel};
      EX_REDIRECT   <= live && taken;
      if (live && taken) begin
        EX_TARGET <= target;
      end
      // Squashing only consumes real instructions; bubbles leave the count alone.
      // A taken transfer seen while squashing is wrong-path and cannot reload.
      if (squash_cnt != '0) begin
        if (DEC_VALID) begin
          squash_cnt <= squash_cnt - CNT_W'(1);
        end
      end else if (DEC_VALID && taken) begin
        squash_cnt <= CNT_W'(SQUASH_DEPTH);
      end
    end
  end

  assign EX_REGWRITE  = ex_ctrl.regwrite;
  assign EX_MEMWRITE  = ex_ctrl.memwrite;
  assign EX_MEMREAD_2 = ex_ctrl.memread2;
  assign EX_RF_WR_SEL = ex_ctrl.rf_wr_sel;

`ifdef OTTER_EXEC_PERF_EN
  always_ff @(posedge REG_CLOCK) begin
    if (!REG_RESET) begin
      EX_BR_TAKEN_CNT <= '0;
      EX_SQUASH_CNT   <= '0;
    end else if (accept) begin
      if (live && taken) begin
        EX_BR_TAKEN_CNT <= EX_BR_TAKEN_CNT + 32'd1;
      end
      if (DEC_VALID && (squash_cnt != '0)) begin
        EX_SQUASH_CNT <= EX_SQUASH_CNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_execute_state.sv
// Directed self-checking bench for execute_state.
module tb_execute_state;

  logic        REG_CLOCK = 1'b0;
  logic        REG_RESET;
  logic        DEC_VALID;
  logic [31:0] DEC_PC_OUT, DEC_ALU_A, DEC_ALU_B, DEC_RS2;
  logic [31:0] DEC_J_TYPE, DEC_B_TYPE, DEC_I_TYPE, DEC_MEM_IR;
  logic [3:0]  DEC_ALU_FUN;
  logic        DEC_REGWRITE, DEC_MEMWRITE, DEC_MEMREAD_2;
  logic [1:0]  DEC_RF_WR_SEL;
  logic        MEM_STALL;
  logic        EX_VALID;
  logic [31:0] EX_ALU_RESULT, EX_RS2, EX_PC_4, EX_MEM_IR, EX_TARGET;
  logic        EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD_2, EX_REDIRECT;
  logic [1:0]  EX_RF_WR_SEL;
`ifdef OTTER_EXEC_PERF_EN
  logic [31:0] EX_BR_TAKEN_CNT, EX_SQUASH_CNT;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] IR_RTYPE = 32'h0000_0033;
  localparam logic [31:0] IR_BEQ   = 32'h0000_0063;
  localparam logic [31:0] IR_BNE   = 32'h0000_1063;
  localparam logic [31:0] IR_B010  = 32'h0000_2063;
  localparam logic [31:0] IR_JAL   = 32'h0000_006F;
  localparam logic [31:0] IR_JALR  = 32'h0000_0067;

  always #5 REG_CLOCK = ~REG_CLOCK;

  execute_state dut (
    .REG_CLOCK     (REG_CLOCK),
    .REG_RESET     (REG_RESET),
    .DEC_VALID     (DEC_VALID),
    .DEC_PC_OUT    (DEC_PC_OUT),
    .DEC_ALU_A     (DEC_ALU_A),
    .DEC_ALU_B     (DEC_ALU_B),
    .DEC_RS2       (DEC_RS2),
    .DEC_J_TYPE    (DEC_J_TYPE),
    .DEC_B_TYPE    (DEC_B_TYPE),
    .DEC_I_TYPE    (DEC_I_TYPE),
    .DEC_MEM_IR    (DEC_MEM_IR),
    .DEC_ALU_FUN   (DEC_ALU_FUN),
    .DEC_REGWRITE  (DEC_REGWRITE),
    .DEC_MEMWRITE  (DEC_MEMWRITE),
    .DEC_MEMREAD_2 (DEC_MEMREAD_2),
    .DEC_RF_WR_SEL (DEC_RF_WR_SEL),
    .MEM_STALL     (MEM_STALL),
    .EX_VALID      (EX_VALID),
    .EX_ALU_RESULT (EX_ALU_RESULT),
    .EX_RS2        (EX_RS2),
    .EX_PC_4       (EX_PC_4),
    .EX_MEM_IR     (EX_MEM_IR),
    .EX_REGWRITE   (EX_REGWRITE),
    .EX_MEMWRITE   (EX_MEMWRITE),
    .EX_MEMREAD_2  (EX_MEMREAD_2),
    .EX_RF_WR_SEL  (EX_RF_WR_SEL),
    .EX_REDIRECT   (EX_REDIRECT),
    .EX_TARGET     (EX_TARGET)
`ifdef OTTER_EXEC_PERF_EN
    ,
    .EX_BR_TAKEN_CNT (EX_BR_TAKEN_CNT),
    .EX_SQUASH_CNT   (EX_SQUASH_CNT)
`endif
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge REG_CLOCK);
    #1;
  endtask

  task automatic bubble();
    DEC_VALID     = 1'b0;
    DEC_PC_OUT    = '0; DEC_ALU_A  = '0; DEC_ALU_B  = '0; DEC_RS2 = '0;
    DEC_J_TYPE    = '0; DEC_B_TYPE = '0; DEC_I_TYPE = '0;
    DEC_MEM_IR    = IR_RTYPE;
    DEC_ALU_FUN   = 4'b0000;
    DEC_REGWRITE  = 1'b0; DEC_MEMWRITE = 1'b0; DEC_MEMREAD_2 = 1'b0;
    DEC_RF_WR_SEL = 2'b00;
  endtask

  task automatic op(input logic [31:0] ir, input logic [31:0] pc4,
                    input logic [31:0] a, input logic [31:0] b, input logic [3:0] fun);
    bubble();
    DEC_VALID   = 1'b1;
    DEC_MEM_IR  = ir;
    DEC_PC_OUT  = pc4;
    DEC_ALU_A   = a;
    DEC_ALU_B   = b;
    DEC_ALU_FUN = fun;
  endtask

  task automatic test_reset();
    REG_RESET = 1'b0;
    MEM_STALL = 1'b0;
    op(IR_JAL, 32'h0000_0200, 32'h1, 32'h2, 4'b0000);
    DEC_REGWRITE = 1'b1; DEC_MEMWRITE = 1'b1; DEC_RF_WR_SEL = 2'b11; DEC_J_TYPE = 32'h40;
    step();
    step();
    vectors++; if (EX_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", EX_VALID); end
    vectors++; if (EX_REDIRECT !== 1'b0) begin miscompares++; $display("FAIL reset_redirect got %b want 0", EX_REDIRECT); end
    vectors++; if (EX_TARGET !== 32'h0) begin miscompares++; $display("FAIL reset_target got %h want 0", EX_TARGET); end
    vectors++; if (EX_ALU_RESULT !== 32'h0) begin miscompares++; $display("FAIL reset_alu got %h want 0", EX_ALU_RESULT); end
    vectors++; if ({EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD_2, EX_RF_WR_SEL} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl got %b want 0", {EX_REGWRITE, EX_MEMWRITE, EX_MEMREAD_2, EX_RF_WR_SEL}); end
    vectors++; if (EX_PC_4 !== 32'h0 || EX_MEM_IR !== 32'h0 || EX_RS2 !== 32'h0) begin
      miscompares++; $display("FAIL reset_data got pc4=%h ir=%h rs2=%h want 0", EX_PC_4, EX_MEM_IR, EX_RS2); end
    REG_RESET = 1'b1;
    bubble();
    step();
  endtask

  task automatic test_alu();
    logic [31:0] a_v [12] = '{32'hFFFF_FFF0, 32'h8000_0000, 32'h1, 32'h5, 32'hFFFF_FFFF, 32'h1,
                              32'h8000_0000, 32'h1234_5000, 32'hF0F0_F0F0, 32'hF0F0_0000,
                              32'hF0F0_F0F0, 32'hDEAD_BEEF};
    logic [31:0] b_v [12] = '{32'h10, 32'h4, 32'hFFFF_FFFF, 32'h7, 32'h1, 32'h21,
                              32'h4, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'h0000_0F0F,
                              32'hFF00_FF00, 32'h1};
    logic [3:0]  f_v [12] = '{4'b0000, 4'b1101, 4'b0011, 4'b1000, 4'b0010, 4'b0001,
                              4'b0101, 4'b1001, 4'b0100, 4'b0110, 4'b0111, 4'b1111};
    logic [31:0] e_v [12] = '{32'h0000_0000, 32'hF800_0000, 32'h1, 32'hFFFF_FFFE, 32'h1, 32'h2,
                              32'h0800_0000, 32'h1234_5000, 32'h0FF0_0FF0, 32'hF0F0_0F0F,
                              32'hF000_F000, 32'h0};
    for (int i = 0; i < 12; i++) begin
      op(IR_RTYPE, 32'h0000_0400 + 32'(i*4), a_v[i], b_v[i], f_v[i]);
      DEC_REGWRITE = 1'b1; DEC_RS2 = 32'h5500_0000 + 32'(i);
      step();
      vectors++; if (EX_ALU_RESULT !== e_v[i]) begin
        miscompares++; $display("FAIL alu_%0d fun=%b got %h want %h", i, f_v[i], EX_ALU_RESULT, e_v[i]); end
    end
    vectors++; if (EX_VALID !== 1'b1 || EX_REGWRITE !== 1'b1 || EX_REDIRECT !== 1'b0) begin
      miscompares++; $display("FAIL alu_ctrl got v=%b rw=%b rd=%b want 1 1 0", EX_VALID, EX_REGWRITE, EX_REDIRECT); end
    vectors++; if (EX_RS2 !== 32'h5500_000B || EX_PC_4 !== 32'h0000_042C) begin
      miscompares++; $display("FAIL alu_data got rs2=%h pc4=%h want 5500000b 0000042c", EX_RS2, EX_PC_4); end
  endtask

  task automatic test_branch_squash();
    // Not-taken branches first: no redirect, no squash.
    op(IR_BNE, 32'h0000_0104, 32'h5, 32'h5, 4'b0000); DEC_RS2 = 32'h5; DEC_B_TYPE = 32'h20;
    step();
    vectors++; if (EX_REDIRECT !== 1'b0 || EX_VALID !== 1'b1) begin
      miscompares++; $display("FAIL bne_not_taken got rd=%b v=%b want 0 1", EX_REDIRECT, EX_VALID); end
    op(IR_B010, 32'h0000_0104, 32'h5, 32'h5, 4'b0000); DEC_RS2 = 32'h5; DEC_B_TYPE = 32'h20;
    step();
    vectors++; if (EX_REDIRECT !== 1'b0) begin
      miscompares++; $display("FAIL f3_010_never got rd=%b want 0", EX_REDIRECT); end
    // Taken BEQ.
    op(IR_BEQ, 32'h0000_0104, 32'h5, 32'h5, 4'b0000); DEC_RS2 = 32'h5; DEC_B_TYPE = 32'h20;
    step();
    vectors++; if (EX_REDIRECT !== 1'b1 || EX_TARGET !== 32'h0000_0120 || EX_VALID !== 1'b1) begin
      miscompares++; $display("FAIL beq_taken got rd=%b tgt=%h v=%b want 1 00000120 1", EX_REDIRECT, EX_TARGET, EX_VALID); end
    // Two squashed slots, the first is a store.
    op(IR_RTYPE, 32'h0000_0108, 32'h1, 32'h1, 4'b0000); DEC_MEMWRITE = 1'b1; DEC_RS2 = 32'hCAFE_0001;
    step();
    vectors++; if (EX_VALID !== 1'b0 || EX_MEMWRITE !== 1'b0 || EX_REDIRECT !== 1'b0) begin
      miscompares++; $display("FAIL squash1 got v=%b mw=%b rd=%b want 0 0 0", EX_VALID, EX_MEMWRITE, EX_REDIRECT); end
    vectors++; if (EX_RS2 !== 32'hCAFE_0001 || EX_TARGET !== 32'h0000_0120) begin
      miscompares++; $display("FAIL squash1_data got rs2=%h tgt=%h want cafe0001 00000120", EX_RS2, EX_TARGET); end
    op(IR_RTYPE, 32'h0000_010C, 32'h1, 32'h1, 4'b0000); DEC_REGWRITE = 1'b1;
    step();
    vectors++; if (EX_VALID !== 1'b0 || EX_REGWRITE !== 1'b0) begin
      miscompares++; $display("FAIL squash2 got v=%b rw=%b want 0 0", EX_VALID, EX_REGWRITE); end
    op(IR_RTYPE, 32'h0000_0124, 32'h1, 32'h1, 4'b0000); DEC_MEMWRITE = 1'b1;
    step();
    vectors++; if (EX_VALID !== 1'b1 || EX_MEMWRITE !== 1'b1) begin
      miscompares++; $display("FAIL after_squash got v=%b mw=%b want 1 1", EX_VALID, EX_MEMWRITE); end
  endtask

  task automatic test_jalr_jal();
    op(IR_JALR, 32'h0000_0300, 32'h0000_1001, 32'h0, 4'b0000); DEC_I_TYPE = 32'h6;
    step();
    vectors++; if (EX_REDIRECT !== 1'b1 || EX_TARGET !== 32'h0000_1006) begin
      miscompares++; $display("FAIL jalr got rd=%b tgt=%h want 1 00001006", EX_REDIRECT, EX_TARGET); end
    // JAL in the first squashed slot: no redirect and no reload of the squash count.
    op(IR_JAL, 32'h0000_2004, 32'h0, 32'h0, 4'b0000); DEC_J_TYPE = 32'h100; DEC_REGWRITE = 1'b1;
    step();
    vectors++; if (EX_REDIRECT !== 1'b0 || EX_VALID !== 1'b0 || EX_TARGET !== 32'h0000_1006) begin
      miscompares++; $display("FAIL jal_squashed got rd=%b v=%b tgt=%h want 0 0 00001006", EX_REDIRECT, EX_VALID, EX_TARGET); end
    op(IR_RTYPE, 32'h0000_2008, 32'h0, 32'h0, 4'b0000);
    step();
    vectors++; if (EX_VALID !== 1'b0) begin
      miscompares++; $display("FAIL jalr_squash2 got v=%b want 0", EX_VALID); end
    op(IR_RTYPE, 32'h0000_1008, 32'h0, 32'h0, 4'b0000);
    step();
    vectors++; if (EX_VALID !== 1'b1) begin
      miscompares++; $display("FAIL no_reload got v=%b want 1", EX_VALID); end
  endtask

  task automatic test_stall();
    op(IR_JAL, 32'h0000_2004, 32'h0, 32'h0, 4'b0000); DEC_J_TYPE = 32'h100; DEC_REGWRITE = 1'b1;
    DEC_RF_WR_SEL = 2'b11;
    step();
    vectors++; if (EX_REDIRECT !== 1'b1 || EX_TARGET !== 32'h0000_2100) begin
      miscompares++; $display("FAIL jal_taken got rd=%b tgt=%h want 1 00002100", EX_REDIRECT, EX_TARGET); end
    // Three stalled cycles with valid, bubble and a taken jump presented.
    MEM_STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) bubble();
      else begin
        op((i == 2) ? IR_JAL : IR_RTYPE, 32'h0000_3000, 32'h7, 32'h7, 4'b0000);
        DEC_MEMWRITE = 1'b1; DEC_J_TYPE = 32'h8;
      end
      step();
      vectors++; if (EX_REDIRECT !== 1'b1 || EX_VALID !== 1'b1 || EX_TARGET !== 32'h0000_2100 ||
                     EX_PC_4 !== 32'h0000_2004 || EX_RF_WR_SEL !== 2'b11 || EX_MEMWRITE !== 1'b0) begin
        miscompares++; $display("FAIL stall_hold_%0d got rd=%b v=%b tgt=%h pc4=%h sel=%b mw=%b", i,
                                EX_REDIRECT, EX_VALID, EX_TARGET, EX_PC_4, EX_RF_WR_SEL, EX_MEMWRITE); end
    end
    MEM_STALL = 1'b0;
    bubble();
    step();
    vectors++; if (EX_REDIRECT !== 1'b0 || EX_VALID !== 1'b0) begin
      miscompares++; $display("FAIL stall_release got rd=%b v=%b want 0 0", EX_REDIRECT, EX_VALID); end
    op(IR_RTYPE, 32'h0000_3004, 32'h1, 32'h2, 4'b0000);
    step();
    vectors++; if (EX_VALID !== 1'b0) begin
      miscompares++; $display("FAIL stall_squash1 got v=%b want 0", EX_VALID); end
    MEM_STALL = 1'b1;
    op(IR_RTYPE, 32'h0000_3008, 32'h1, 32'h2, 4'b0000);
    step();
    MEM_STALL = 1'b0;
    bubble();
    step();
    op(IR_RTYPE, 32'h0000_300C, 32'h1, 32'h2, 4'b0000);
    step();
    vectors++; if (EX_VALID !== 1'b0 || EX_PC_4 !== 32'h0000_300C) begin
      miscompares++; $display("FAIL stall_squash2 got v=%b pc4=%h want 0 0000300c", EX_VALID, EX_PC_4); end
    op(IR_RTYPE, 32'h0000_3010, 32'h1, 32'h2, 4'b0000);
    step();
    vectors++; if (EX_VALID !== 1'b1 || EX_ALU_RESULT !== 32'h3) begin
      miscompares++; $display("FAIL stall_live got v=%b alu=%h want 1 00000003", EX_VALID, EX_ALU_RESULT); end
  endtask

  task automatic test_reset_mid_squash();
    op(IR_BEQ, 32'h0000_0504, 32'h9, 32'h9, 4'b0000); DEC_RS2 = 32'h9; DEC_B_TYPE = 32'h10;
    step();
    vectors++; if (EX_REDIRECT !== 1'b1 || EX_TARGET !== 32'h0000_0510) begin
      miscompares++; $display("FAIL mid_beq got rd=%b tgt=%h want 1 00000510", EX_REDIRECT, EX_TARGET); end
    op(IR_RTYPE, 32'h0000_0508, 32'h1, 32'h1, 4'b0000);
    step();
    REG_RESET = 1'b0;
    MEM_STALL = 1'b1;
    step();
    vectors++; if (EX_VALID !== 1'b0 || EX_TARGET !== 32'h0 || EX_PC_4 !== 32'h0) begin
      miscompares++; $display("FAIL mid_reset got v=%b tgt=%h pc4=%h want 0 0 0", EX_VALID, EX_TARGET, EX_PC_4); end
    REG_RESET = 1'b1;
    MEM_STALL = 1'b0;
    op(IR_RTYPE, 32'h0000_0600, 32'h1, 32'h1, 4'b0000); DEC_REGWRITE = 1'b1;
    step();
    vectors++; if (EX_VALID !== 1'b1 || EX_REGWRITE !== 1'b1) begin
      miscompares++; $display("FAIL after_mid_reset got v=%b rw=%b want 1 1", EX_VALID, EX_REGWRITE); end
  endtask

  initial begin
    bubble();
    test_reset();
    test_alu();
    test_branch_squash();
    test_jalr_jal();
    test_stall();
    test_reset_mid_squash();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
